serial_io_scheduler: RTL and testbench

//  Owns the shared serial-peripheral clock o_PSCLK and time-multiplexes it between
//  the LED shift chain (out), 7-seg shift chain (out) and DIP switch chain (in).

---
 rtl/serial_io_scheduler_if.sv | 43 ++++
 rtl/serial_io_scheduler.sv | 207 ++++++++++++++++++++
 tb/tb_serial_io_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_io_scheduler_if.sv
//============================================================================
// Module  : serial_io_scheduler_if
// Brief   : Request/data side and board-pin side of the serial I/O scheduler.
// Rev     : 1.0  initial release
//============================================================================
`default_nettype none

interface serial_io_scheduler_if #(
    parameter int LED_BITS = 16,
    parameter int SEG_BITS = 32,
    parameter int DIP_BITS = 8
);
    logic                i_led_req;
    logic [LED_BITS-1:0] i_led_data;
    logic                i_seg_req;
    logic [SEG_BITS-1:0] i_seg_data;
    logic                i_dip_req;
    logic [DIP_BITS-1:0] o_dip_value;
    logic                o_dip_valid;
    logic                o_busy;
    logic                o_PSCLK;
    logic                o_LEDData;
    logic                o_LEDLatch;
    logic                o_SEGData;
    logic                o_SEGLatch;
    logic                o_DIPLatch;
    logic                i_DIPData;

    // master: user logic plus board; slave: the scheduler itself
    modport master (
        output i_led_req, i_led_data, i_seg_req, i_seg_data, i_dip_req, i_DIPData,
        input  o_dip_value, o_dip_valid, o_busy, o_PSCLK,
        input  o_LEDData, o_LEDLatch, o_SEGData, o_SEGLatch, o_DIPLatch
    );

    modport slave (
        input  i_led_req, i_led_data, i_seg_req, i_seg_data, i_dip_req, i_DIPData,
        output o_dip_value, o_dip_valid, o_busy, o_PSCLK,
        output o_LEDData, o_LEDLatch, o_SEGData, o_SEGLatch, o_DIPLatch
    );
endinterface

`default_nettype wire

// File: rtl/serial_io_scheduler.sv
//============================================================================
// Module  : serial_io_scheduler
// Brief   : Round-robin owner of the shared PSCLK serving LED, 7-seg and DIP chains.
// Rev     : 1.0  initial release
//============================================================================
`default_nettype none

module serial_io_scheduler #(
    parameter int CLK_DIV  = 5,
    parameter int LED_BITS = 16,
    parameter int SEG_BITS = 32,
    parameter int DIP_BITS = 8
) (
    input wire                   i_CLK,
    input wire                   i_SYS_RESET,
    serial_io_scheduler_if.slave bus
);
    localparam int SHIFT_W = (LED_BITS > SEG_BITS)
                           ? ((LED_BITS > DIP_BITS) ? LED_BITS : DIP_BITS)
                           : ((SEG_BITS > DIP_BITS) ? SEG_BITS : DIP_BITS);
    localparam int BIT_CW  = $clog2(SHIFT_W + 1);
    localparam int DIV_CW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_CW-1:0] DIV_LAST = DIV_CW'(CLK_DIV - 1);
    localparam logic [BIT_CW-1:0] LED_LAST = BIT_CW'(LED_BITS - 1);
    localparam logic [BIT_CW-1:0] SEG_LAST = BIT_CW'(SEG_BITS - 1);
    localparam logic [BIT_CW-1:0] DIP_LAST = BIT_CW'(DIP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GRANT  = 3'd1,
        S_SHIFT  = 3'd2,
        S_LATCH  = 3'd3,
        S_LOAD   = 3'd4,
        S_DSHIFT = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        CH_LED = 2'd0,
        CH_SEG = 2'd1,
        CH_DIP = 2'd2
    } chan_t;

    state_t              state;
    state_t              state_nxt;
    chan_t               chan;
    chan_t               pick;
    chan_t               rr_first;
    logic [2:0]          pending;
    logic [2:0]          req_vec;
    logic [2:0]          grant_vec;
    logic [DIV_CW-1:0]   div_cnt;
    logic                phase;
    logic [BIT_CW-1:0]   bit_cnt;
    logic [BIT_CW-1:0]   bit_last;
    logic [SHIFT_W-1:0]  shift_reg;
    logic [DIP_BITS-1:0] dip_value;
    logic                half_end;
    logic                bit_end;
    logic                last_bit;

    function automatic chan_t chan_after(input chan_t c);
        case (c)
            CH_LED:  return CH_SEG;
            CH_SEG:  return CH_DIP;
            default: return CH_LED;
        endcase
    endfunction

    // rr_first names the channel with top priority at the next grant
    always_comb begin
        pick = chan_after(chan_after(rr_first));
        if (pending[rr_first]) begin
            pick = rr_first;
        end else if (pending[chan_after(rr_first)]) begin
            pick = chan_after(rr_first);
        end
    end

    always_comb begin
        case (chan)
            CH_LED:  bit_last = LED_LAST;
            CH_SEG:  bit_last = SEG_LAST;
            default: bit_last = DIP_LAST;
        endcase
    end

    assign req_vec   = {bus.i_dip_req, bus.i_seg_req, bus.i_led_req};
    assign grant_vec = (state == S_GRANT) ? (3'b001 << pick) : 3'b000;
    assign half_end  = (div_cnt == DIV_LAST);
    assign bit_end   = half_end & phase;
    assign last_bit  = (bit_cnt == bit_last);

    always_ff @(posedge i_CLK or negedge i_SYS_RESET) begin
        if (!i_SYS_RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        bus.o_PSCLK     = 1'b0;
        bus.o_LEDData   = 1'b0;
        bus.o_SEGData   = 1'b0;
        bus.o_LEDLatch  = 1'b0;
        bus.o_SEGLatch  = 1'b0;
        bus.o_DIPLatch  = 1'b1;
        bus.o_dip_valid = 1'b0;
        bus.o_busy      = 1'b1;
        case (state)
            S_IDLE: begin
                bus.o_busy = 1'b0;
                if (|pending) state_nxt = S_GRANT;
            end
            S_GRANT: begin
                state_nxt = (pick == CH_DIP) ? S_LOAD : S_SHIFT;
            end
            S_SHIFT: begin
                bus.o_PSCLK   = phase;
                bus.o_LEDData = (chan == CH_LED) & shift_reg[SHIFT_W-1];
                bus.o_SEGData = (chan == CH_SEG) & shift_reg[SHIFT_W-1];
                if (bit_end && last_bit) state_nxt = S_LATCH;
            end
            S_LATCH: begin
                bus.o_LEDLatch = (chan == CH_LED);
                bus.o_SEGLatch = (chan == CH_SEG);
                if (bit_end) state_nxt = S_DONE;
            end
            S_LOAD: begin
                bus.o_DIPLatch = 1'b0;
                if (bit_end) state_nxt = S_DSHIFT;
            end
            S_DSHIFT: begin
                bus.o_PSCLK = phase;
                if (bit_end && last_bit) state_nxt = S_DONE;
            end
            S_DONE: begin
                bus.o_dip_valid = (chan == CH_DIP);
                state_nxt       = (|pending) ? S_GRANT : S_IDLE;
            end
            default: begin
                bus.o_busy = 1'b0;
                state_nxt  = S_IDLE;
            end
        endcase
    end

    assign bus.o_dip_value = dip_value;

    // A request arriving in the grant cycle of its own channel must survive the clear
    always_ff @(posedge i_CLK or negedge i_SYS_RESET) begin
        if (!i_SYS_RESET) begin
            pending   <= 3'b000;
            rr_first  <= CH_LED;
            chan      <= CH_LED;
            div_cnt   <= '0;
            phase     <= 1'b0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            dip_value <= '0;
        end else begin
            pending <= (pending & ~grant_vec) | req_vec;
            case (state)
                S_GRANT: begin
                    chan    <= pick;
                    div_cnt <= '0;
                    phase   <= 1'b0;
                    bit_cnt <= '0;
                    case (pick)
                        CH_LED:  shift_reg <= SHIFT_W'(bus.i_led_data) << (SHIFT_W - LED_BITS);
                        CH_SEG:  shift_reg <= SHIFT_W'(bus.i_seg_data) << (SHIFT_W - SEG_BITS);
                        default: shift_reg <= '0;
                    endcase
                end
                S_SHIFT, S_LATCH, S_LOAD, S_DSHIFT: begin
                    if (half_end) begin
                        div_cnt <= '0;
                        phase   <= ~phase;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                    if (state == S_SHIFT && bit_end) begin
                        shift_reg <= shift_reg << 1;
                        bit_cnt   <= bit_cnt + 1'b1;
                    end
                    // DIP data is taken on the last cycle before PSCLK rises
                    if (state == S_DSHIFT && half_end && !phase) begin
                        shift_reg <= {shift_reg[SHIFT_W-2:0], bus.i_DIPData};
                    end
                    if (state == S_DSHIFT && bit_end) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (last_bit) dip_value <= shift_reg[DIP_BITS-1:0];
                    end
                end
                S_DONE: begin
                    rr_first <= chan_after(chan);
                end
                default: ;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_serial_io_scheduler.sv
//============================================================================
// Module  : tb_serial_io_scheduler
// Brief   : Self-checking bench with DIP chain model and frame-order reference.
// Rev     : 1.0  initial release
//============================================================================
`default_nettype none

module tb_serial_io_scheduler;
    localparam int CLK_DIV  = 2;
    localparam int LED_BITS = 16;
    localparam int SEG_BITS = 32;
    localparam int DIP_BITS = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_io_scheduler_if #(.LED_BITS(LED_BITS), .SEG_BITS(SEG_BITS), .DIP_BITS(DIP_BITS)) bus ();

    serial_io_scheduler #(
        .CLK_DIV (CLK_DIV),
        .LED_BITS(LED_BITS),
        .SEG_BITS(SEG_BITS),
        .DIP_BITS(DIP_BITS)
    ) dut (
        .i_CLK      (clk),
        .i_SYS_RESET(rst_n),
        .bus        (bus)
    );

    int checks = 0;
    int errors = 0;

    // DIP switch chain: parallel load while latch low, shift on PSCLK rise
    logic [DIP_BITS-1:0] dip_sw    = '0;
    logic [DIP_BITS-1:0] dip_chain = '0;
    logic                dev_ps_q  = 1'b0;
    always @(posedge clk) begin
        if (!bus.o_DIPLatch) dip_chain <= dip_sw;
        else if (bus.o_PSCLK && !dev_ps_q) dip_chain <= dip_chain << 1;
        dev_ps_q <= bus.o_PSCLK;
    end
    assign bus.i_DIPData = dip_chain[DIP_BITS-1];

    int          pulses = 0, bit_n = 0, led_run = 0, seg_run = 0;
    int          led_latch_len = 0, seg_latch_len = 0;
    int          valid_cnt = 0, valid_wide = 0, overlap = 0, stray = 0;
    logic [31:0] led_sh = '0, seg_sh = '0, valid_val = '0;
    logic        ps_q = 1'b0, ledl_q = 1'b0, segl_q = 1'b0, dipl_q = 1'b1, valid_q = 1'b0;
    int          log_ch[$];
    logic [31:0] log_val[$];
    int          log_bits[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            bit_n   = 0;
            led_run = 0;
            seg_run = 0;
        end else begin
            if (bus.o_PSCLK && !ps_q) begin
                pulses++;
                bit_n++;
                led_sh = {led_sh[30:0], bus.o_LEDData};
                seg_sh = {seg_sh[30:0], bus.o_SEGData};
            end
            if (bus.o_LEDLatch) led_run++;
            if (bus.o_SEGLatch) seg_run++;
            if (bus.o_LEDLatch && !ledl_q) begin
                log_ch.push_back(0); log_val.push_back({16'h0, led_sh[15:0]});
                log_bits.push_back(bit_n); bit_n = 0;
            end
            if (bus.o_SEGLatch && !segl_q) begin
                log_ch.push_back(1); log_val.push_back(seg_sh);
                log_bits.push_back(bit_n); bit_n = 0;
            end
            if (!bus.o_LEDLatch && ledl_q) begin led_latch_len = led_run; led_run = 0; end
            if (!bus.o_SEGLatch && segl_q) begin seg_latch_len = seg_run; seg_run = 0; end
            if (!bus.o_DIPLatch && dipl_q) begin
                log_ch.push_back(2); log_val.push_back({24'h0, dip_sw});
                log_bits.push_back(0); bit_n = 0;
            end
            if (bus.o_dip_valid) begin
                valid_cnt++;
                valid_val = {24'h0, bus.o_dip_value};
                if (valid_q) valid_wide++;
                bit_n = 0;
            end
            if ((int'(bus.o_LEDData | bus.o_LEDLatch) + int'(bus.o_SEGData | bus.o_SEGLatch)
                 + int'(!bus.o_DIPLatch)) > 1) overlap++;
            if (bus.o_PSCLK && !bus.o_busy) stray++;
        end
        ps_q    = bus.o_PSCLK;
        ledl_q  = bus.o_LEDLatch;
        segl_q  = bus.o_SEGLatch;
        dipl_q  = bus.o_DIPLatch;
        valid_q = bus.o_dip_valid;
    end

    // Reference: channels served in rotation after the last one served
    int          last_served = 2;
    int          exp_ch[$];
    logic [31:0] exp_val[$];

    task automatic model_serve(input logic [2:0] mask);
        int base = last_served;
        for (int k = 1; k <= 3; k++) begin
            int c = (base + k) % 3;
            if (mask[c]) begin
                exp_ch.push_back(c);
                if (c == 0)      exp_val.push_back({16'h0, bus.i_led_data});
                else if (c == 1) exp_val.push_back(bus.i_seg_data);
                else             exp_val.push_back({24'h0, dip_sw});
                last_served = c;
            end
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_frames(input string tag);
        check({tag, "_frames"}, log_ch.size(), exp_ch.size());
        for (int i = 0; i < exp_ch.size() && i < log_ch.size(); i++) begin
            check($sformatf("%s_ch%0d", tag, i), log_ch[i], exp_ch[i]);
            check($sformatf("%s_val%0d", tag, i), log_val[i], exp_val[i]);
            if (exp_ch[i] != 2)
                check($sformatf("%s_bits%0d", tag, i), log_bits[i],
                      (exp_ch[i] == 0) ? LED_BITS : SEG_BITS);
        end
        log_ch.delete(); log_val.delete(); log_bits.delete();
        exp_ch.delete(); exp_val.delete();
    endtask

    task automatic strobe(input logic [2:0] mask);
        @(negedge clk);
        bus.i_led_req = mask[0];
        bus.i_seg_req = mask[1];
        bus.i_dip_req = mask[2];
        @(negedge clk);
        bus.i_led_req = 1'b0;
        bus.i_seg_req = 1'b0;
        bus.i_dip_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int quiet = 0;
        int n     = 0;
        while (quiet < 3 && n < max_cyc) begin
            @(negedge clk);
            n++;
            quiet = bus.o_busy ? 0 : quiet + 1;
        end
        check({tag, "_idle_wait"}, quiet >= 3, 1'b1);
    endtask

    task automatic wait_pulses(input string tag, input int target, input int max_cyc);
        int n = 0;
        while (pulses < target && n < max_cyc) begin @(negedge clk); n++; end
        check({tag, "_pulse_wait"}, pulses >= target, 1'b1);
    endtask

    task automatic wait_log(input string tag, input int target, input int max_cyc);
        int n = 0;
        while (log_ch.size() < target && n < max_cyc) begin @(negedge clk); n++; end
        check({tag, "_log_wait"}, log_ch.size() >= target, 1'b1);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_psclk"},  bus.o_PSCLK,     1'b0);
        check({tag, "_ledd"},   bus.o_LEDData,   1'b0);
        check({tag, "_segd"},   bus.o_SEGData,   1'b0);
        check({tag, "_ledl"},   bus.o_LEDLatch,  1'b0);
        check({tag, "_segl"},   bus.o_SEGLatch,  1'b0);
        check({tag, "_dipl"},   bus.o_DIPLatch,  1'b1);
        check({tag, "_dipv"},   bus.o_dip_value, 8'h00);
        check({tag, "_valid"},  bus.o_dip_valid, 1'b0);
        check({tag, "_busy"},   bus.o_busy,      1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: observed=no finish expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int p0, v0;
        logic [31:0] seg_v;
        bus.i_led_req  = 1'b0;
        bus.i_seg_req  = 1'b0;
        bus.i_dip_req  = 1'b0;
        bus.i_led_data = '0;
        bus.i_seg_data = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        reset_checks("rst0");
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_busy", bus.o_busy, 1'b0);

        // LED frame with known pattern
        bus.i_led_data = 16'hA5C3;
        p0 = pulses;
        strobe(3'b001);
        model_serve(3'b001);
        wait_idle("led", 400);
        compare_frames("led");
        check("led_pulses", pulses - p0, LED_BITS);
        check("led_latch_len", led_latch_len, 2 * CLK_DIV);

        // DIP read
        dip_sw = 8'h5A;
        v0 = valid_cnt;
        strobe(3'b100);
        model_serve(3'b100);
        wait_idle("dip", 400);
        compare_frames("dip");
        check("dip_valid_cnt", valid_cnt - v0, 1);
        check("dip_valid_val", valid_val, 32'h5A);
        check("dip_value", bus.o_dip_value, 8'h5A);

        // Round robin: all three together, then LED+DIP
        bus.i_led_data = 16'h1234;
        bus.i_seg_data = 32'hDEADBEEF;
        dip_sw         = 8'hC3;
        strobe(3'b111);
        model_serve(3'b111);
        wait_idle("rr3", 1000);
        check("rr3_first", log_ch.size() > 0 ? log_ch[0] : -1, 0);
        compare_frames("rr3");
        strobe(3'b101);
        model_serve(3'b101);
        wait_idle("rr2", 1000);
        compare_frames("rr2");

        // Random request mixes
        for (int it = 0; it < 6; it++) begin
            logic [2:0] mask;
            bus.i_led_data = 16'($urandom);
            bus.i_seg_data = $urandom;
            dip_sw         = 8'($urandom);
            mask           = 3'($urandom_range(1, 7));
            v0 = valid_cnt;
            strobe(mask);
            model_serve(mask);
            wait_idle($sformatf("rnd%0d", it), 1000);
            compare_frames($sformatf("rnd%0d", it));
            check($sformatf("rnd%0d_valid", it), valid_cnt - v0, int'(mask[2]));
        end

        // Coalesced SEG requests during an LED frame, data changed after grant
        bus.i_led_data = 16'($urandom);
        seg_v          = $urandom;
        bus.i_seg_data = seg_v;
        p0 = pulses;
        strobe(3'b001);
        model_serve(3'b001);
        wait_pulses("coal_led", p0 + 3, 200);
        strobe(3'b010);
        @(negedge clk);
        strobe(3'b010);
        strobe(3'b010);
        model_serve(3'b010);
        bus.i_led_data = ~bus.i_led_data;
        wait_log("coal", 1, 400);
        wait_pulses("coal_seg", pulses + 1, 100);
        bus.i_seg_data = ~seg_v;
        wait_idle("coal", 1000);
        compare_frames("coal");
        check("overlap", overlap, 0);
        check("stray_psclk", stray, 0);

        // Asynchronous reset in the middle of an LED frame
        p0 = pulses;
        strobe(3'b001);
        wait_pulses("rstled", p0 + 5, 200);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 reset_checks("rst_mid");
        p0 = pulses;
        repeat (3) @(negedge clk);
        check("rst_hold_pulses", pulses - p0, 0);
        rst_n = 1'b1;
        last_served = 2;
        log_ch.delete(); log_val.delete(); log_bits.delete();
        repeat (20) @(negedge clk);
        check("rst_no_replay_busy", bus.o_busy, 1'b0);
        check("rst_no_replay_pulses", pulses - p0, 0);

        // Asynchronous reset after four DIP bits
        dip_sw = 8'($urandom) | 8'h81;
        v0 = valid_cnt;
        p0 = pulses;
        strobe(3'b100);
        wait_pulses("rstdip", p0 + 4, 200);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rstdip_valid", bus.o_dip_valid, 1'b0);
        check("rstdip_value", bus.o_dip_value, 8'h00);
        check("rstdip_dipl", bus.o_DIPLatch, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        p0 = pulses;
        repeat (40) @(negedge clk);
        check("rstdip_no_valid", valid_cnt - v0, 0);
        check("rstdip_value_after", bus.o_dip_value, 8'h00);
        check("rstdip_pending_clr", pulses - p0, 0);
        check("rstdip_busy", bus.o_busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
